// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-side front end for the register file. It merges the in-order
//   pipeline writeback with results returned by a long-latency unit. The
//   long-latency results are buffered in a small FIFO. The block also keeps
//   a per-register pending-write scoreboard for ID hazard checks, and raises
//   a stall request when buffered results are starved by the pipeline.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   pipe_we/pipe_waddr/pipe_wdata    pipeline writeback (never back-pressured)
//   lu_valid/lu_ready/lu_waddr/lu_wdata  long-latency return handshake
//   sb_set/sb_addr                   mark a destination pending at issue
//   rd_addr_1/rd_addr_2 -> busy_1/busy_2  combinational scoreboard lookups
//   stall_req                        ask the pipeline to suppress pipe_we
//   we/waddr/wdata                   register file write port (registered)
//   fifo_count                       current FIFO occupancy
module regfile_wb_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int REG_NUM      = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_we,
    input  logic [ADDR_W-1:0]             pipe_waddr,
    input  logic [DATA_W-1:0]             pipe_wdata,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [ADDR_W-1:0]             lu_waddr,
    input  logic [DATA_W-1:0]             lu_wdata,
    input  logic                          sb_set,
    input  logic [ADDR_W-1:0]             sb_addr,
    input  logic [ADDR_W-1:0]             rd_addr_1,
    input  logic [ADDR_W-1:0]             rd_addr_2,
    output logic                          busy_1,
    output logic                          busy_2,
    output logic                          stall_req,
    output logic                          we,
    output logic [ADDR_W-1:0]             waddr,
    output logic [DATA_W-1:0]             wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    // FIFO storage and bookkeeping
    logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              we_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic [ST_W-1:0]   starve_reg;
    logic [ST_W-1:0]   starve_next;
    logic              stall_reg;

    logic [REG_NUM-1:0] busy_reg;
    logic [REG_NUM-1:0] set_vec;
    logic [REG_NUM-1:0] clr_vec;

    logic              pipe_win;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Readiness comes from the start-of-cycle count only, so a pop in the
    // same cycle never opens a slot for a push.
    assign lu_ready   = (count_reg < CNT_W'(FIFO_DEPTH)) && !rst;
    assign fifo_empty = (count_reg == '0);
    // A write to r0 is architecturally a no-op, so it does not claim the port.
    assign pipe_win   = pipe_we && (pipe_waddr != '0);
    assign pop        = !pipe_win && !fifo_empty;
    // Returns targeting r0 complete the handshake but are dropped.
    assign push       = lu_valid && lu_ready && (lu_waddr != '0);
    assign head_addr  = fifo_addr_mem[rd_ptr_reg];
    assign head_data  = fifo_data_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_reg] <= lu_waddr;
            fifo_data_mem[wr_ptr_reg] <= lu_wdata;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Register file write port. Address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else if (pipe_win) begin
            we_reg    <= 1'b1;
            waddr_reg <= pipe_waddr;
            wdata_reg <= pipe_wdata;
        end else if (pop) begin
            we_reg    <= 1'b1;
            waddr_reg <= head_addr;
            wdata_reg <= head_data;
        end else begin
            we_reg    <= 1'b0;
        end
    end

    // Starvation counter: counts cycles where buffered data loses to the
    // pipeline. Any pop or an empty FIFO clears it.
    always_comb begin
        starve_next = starve_reg;
        if (pop || fifo_empty) begin
            starve_next = '0;
        end else if (starve_reg < ST_W'(STARVE_LIMIT)) begin
            starve_next = starve_reg + ST_W'(1);
        end
    end

    // stall_req is registered from the next counter value, so it always
    // equals (starve_reg >= STARVE_LIMIT). It drops the cycle after a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_reg <= '0;
            stall_reg  <= 1'b0;
        end else begin
            starve_reg <= starve_next;
            stall_reg  <= (starve_next >= ST_W'(STARVE_LIMIT));
        end
    end

    // Scoreboard decode. Bit 0 is never set.
    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign set_vec[gi] = 1'b0;
                assign clr_vec[gi] = 1'b0;
            end else begin : g_reg
                assign set_vec[gi] = sb_set && (sb_addr == ADDR_W'(gi));
                assign clr_vec[gi] = pop && (head_addr == ADDR_W'(gi));
            end
        end
    endgenerate

    // If a set and a clear hit the same address, the set wins. The pending
    // write belongs to the newer op.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= (busy_reg & ~clr_vec) | set_vec;
        end
    end

    assign busy_1     = busy_reg[rd_addr_1];
    assign busy_2     = busy_reg[rd_addr_2];
    assign stall_req  = stall_reg;
    assign we         = we_reg;
    assign waddr      = waddr_reg;
    assign wdata      = wdata_reg;
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Inputs are driven 1 time unit after
// the rising edge. Outputs are checked at that point or later, never on an edge.
module tb_regfile_wb_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_waddr;
    logic [DATA_W-1:0] lu_wdata;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic              busy_1;
    logic              busy_2;
    logic              stall_req;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        fifo_count;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(
        .ADDR_W(5), .DATA_W(32), .REG_NUM(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready),
        .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .busy_1(busy_1), .busy_2(busy_2), .stall_req(stall_req),
        .we(we), .waddr(waddr), .wdata(wdata), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
        sb_set = 1'b0; sb_addr = '0;
        rd_addr_1 = 5'd8; rd_addr_2 = '0;

        // Reset state
        tick(); tick();
        chk("rst_we",        32'(we), 0);
        chk("rst_waddr",     32'(waddr), 0);
        chk("rst_wdata",     wdata, 0);
        chk("rst_stall",     32'(stall_req), 0);
        chk("rst_count",     32'(fifo_count), 0);
        chk("rst_busy1",     32'(busy_1), 0);
        chk("rst_lu_ready",  32'(lu_ready), 0);
        rst = 1'b0;
        #1;
        chk("rel_lu_ready",  32'(lu_ready), 1);

        // Pipeline write: one cycle latency
        pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234;
        tick();
        pipe_we = 1'b0;
        chk("pipe_we",       32'(we), 1);
        chk("pipe_waddr",    32'(waddr), 5);
        chk("pipe_wdata",    wdata, 32'h1234);
        tick();
        chk("pipe_we_off",   32'(we), 0);
        chk("pipe_hold",     32'(waddr), 5);
        $display("txn pipe write r5=0x1234 done");

        // Scoreboard set and long-latency return
        sb_set = 1'b1; sb_addr = 5'd8;
        tick();
        sb_set = 1'b0;
        #1;
        chk("sb_busy1",      32'(busy_1), 1);
        chk("sb_busy2_r0",   32'(busy_2), 0);
        lu_valid = 1'b1; lu_waddr = 5'd8; lu_wdata = 32'hDEAD;
        #1;
        chk("lu_ready_empty", 32'(lu_ready), 1);
        tick();
        lu_valid = 1'b0;
        chk("lu_count1",     32'(fifo_count), 1);
        chk("lu_no_bypass",  32'(we), 0);
        chk("lu_busy_held",  32'(busy_1), 1);
        tick();
        chk("lu_we",         32'(we), 1);
        chk("lu_waddr",      32'(waddr), 8);
        chk("lu_wdata",      wdata, 32'hDEAD);
        chk("lu_busy_clr",   32'(busy_1), 0);
        chk("lu_count0",     32'(fifo_count), 0);
        $display("txn lu write r8=0xDEAD done");

        // Starvation with a pipeline that keeps winning
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h33;
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
        tick();
        chk("st_count1",     32'(fifo_count), 1);
        chk("st_pipe_wins",  32'(waddr), 3);
        lu_waddr = 5'd10; lu_wdata = 32'hAA;
        tick();
        lu_valid = 1'b0;
        #1;
        chk("st_count2",     32'(fifo_count), 2);
        chk("st_full_ready", 32'(lu_ready), 0);
        chk("st_stall_b1",   32'(stall_req), 0);
        tick(); tick();
        chk("st_stall_b3",   32'(stall_req), 0);
        tick();
        chk("st_stall_b4",   32'(stall_req), 1);
        chk("st_pipe_we",    32'(we), 1);
        chk("st_pipe_addr",  32'(waddr), 3);
        $display("txn starvation stall raised");

        // Full FIFO popping with lu_valid: no push this cycle
        pipe_we = 1'b0;
        lu_valid = 1'b1; lu_waddr = 5'd11; lu_wdata = 32'hBB;
        #1;
        chk("fp_ready_full", 32'(lu_ready), 0);
        tick();
        chk("fp_waddr9",     32'(waddr), 9);
        chk("fp_wdata9",     wdata, 32'h99);
        chk("fp_stall_fall", 32'(stall_req), 0);
        chk("fp_count1",     32'(fifo_count), 1);
        chk("fp_ready_now",  32'(lu_ready), 1);
        tick();
        lu_valid = 1'b0;
        chk("fp_waddr10",    32'(waddr), 10);
        chk("fp_wdata10",    wdata, 32'hAA);
        chk("fp_count_pp",   32'(fifo_count), 1);
        tick();
        chk("fp_waddr11",    32'(waddr), 11);
        chk("fp_wdata11",    wdata, 32'hBB);
        chk("fp_count0",     32'(fifo_count), 0);
        tick();
        chk("fp_idle",       32'(we), 0);
        $display("txn ordered drain r9 r10 r11 done");

        // r0 handshake is discarded
        lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'h55;
        #1;
        chk("z_ready",       32'(lu_ready), 1);
        tick();
        lu_valid = 1'b0;
        chk("z_count",       32'(fifo_count), 0);
        tick();
        chk("z_no_write",    32'(we), 0);

        // Pipeline write to r0 lets the FIFO drain
        lu_valid = 1'b1; lu_waddr = 5'd12; lu_wdata = 32'hCC;
        pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h77;
        tick();
        lu_valid = 1'b0;
        chk("p0_count",      32'(fifo_count), 1);
        chk("p0_no_write",   32'(we), 0);
        tick();
        chk("p0_we",         32'(we), 1);
        chk("p0_waddr",      32'(waddr), 12);
        chk("p0_wdata",      wdata, 32'hCC);
        $display("txn r0 cases done");

        // Reset mid-operation
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h33;
        sb_set = 1'b1; sb_addr = 5'd9; rd_addr_1 = 5'd9;
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h91;
        tick();
        sb_set = 1'b0;
        lu_waddr = 5'd10; lu_wdata = 32'hA1;
        tick();
        lu_valid = 1'b0; pipe_we = 1'b0;
        chk("mr_count2",     32'(fifo_count), 2);
        chk("mr_busy9",      32'(busy_1), 1);
        rst = 1'b1;
        tick();
        chk("mr_count0",     32'(fifo_count), 0);
        chk("mr_busy_clr",   32'(busy_1), 0);
        chk("mr_we",         32'(we), 0);
        chk("mr_waddr",      32'(waddr), 0);
        chk("mr_stall",      32'(stall_req), 0);
        chk("mr_ready_rst",  32'(lu_ready), 0);
        rst = 1'b0;
        #1;
        chk("mr_ready",      32'(lu_ready), 1);
        tick();
        chk("mr_no_drain",   32'(we), 0);
        $display("txn reset mid-operation done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side front end for the register file. Merges two writeback sources into the register file's single write port (we/waddr/wdata):
  - the in-order pipeline WB stage;
  - a long-latency unit (load-miss / multi-cycle mult-div) that returns results through a valid/ready handshake.
- Buffers long-latency returns in a small FIFO.
- Keeps a per-register pending-write scoreboard that ID uses for hazard stalls.
- Drives a stall request to the pipeline when buffered results are starved.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- REG_NUM, 32, number of architectural registers (2**ADDR_W).
- FIFO_DEPTH, 2, long-latency return buffer entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive blocked cycles before stall_req asserts.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- pipe_we  in  1  pipeline writeback valid; never back-pressured.
- pipe_waddr  in  ADDR_W  pipeline destination register.
- pipe_wdata  in  DATA_W  pipeline result.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  arbiter can accept a long-latency result.
- lu_waddr  in  ADDR_W  long-latency destination register.
- lu_wdata  in  DATA_W  long-latency result.
- sb_set  in  1  long-latency op issued; mark sb_addr pending.
- sb_addr  in  ADDR_W  destination of the issued long-latency op.
- rd_addr_1  in  ADDR_W  ID source register 1 to check.
- rd_addr_2  in  ADDR_W  ID source register 2 to check.
- busy_1  out  1  rd_addr_1 has a pending long-latency write.
- busy_2  out  1  rd_addr_2 has a pending long-latency write.
- stall_req  out  1  request that the pipeline suppress pipe_we.
- we  out  1  register file write enable.
- waddr  out  ADDR_W  register file write address.
- wdata  out  DATA_W  register file write data.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - we=0, waddr=0, wdata=0, stall_req=0.
  - FIFO emptied, fifo_count=0; pointers=0.
  - All busy bits=0; starve counter=0.
  - Reset mid-operation discards all buffered entries and pending state.
- lu_ready:
  - lu_ready = (fifo_count < FIFO_DEPTH) && !rst, evaluated on the start-of-cycle count.
  - A pop in the same cycle does NOT make a full FIFO ready.
- Accept: lu_valid && lu_ready at a posedge.
  - lu_waddr != 0: entry is pushed.
  - lu_waddr == 0: handshake completes but the entry is discarded (not pushed).
  - lu_valid without lu_ready: producer must hold lu_waddr/lu_wdata stable.
- Arbitration, per cycle, using start-of-cycle state:
  - pipe_we && pipe_waddr != 0: pipeline wins. Next cycle we=1, waddr/wdata = pipe values.
  - Otherwise, if the FIFO is non-empty: pop the head. Next cycle we=1, waddr/wdata = head values.
  - Otherwise: next cycle we=0; waddr/wdata hold their previous values.
  - pipe_we with pipe_waddr == 0 counts as no pipeline write, so the FIFO may drain.
- Latency:
  - Pipeline write: 1 cycle (presented in cycle N, we=1 in cycle N+1; register file commits on that cycle's negedge).
  - Long-latency write: minimum 2 cycles (handshake in N, pop in N+1, we in N+2). No bypass around the FIFO.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Strict FIFO order between long-latency results.
  - Simultaneous push and pop: count unchanged.
- Scoreboard (busy[REG_NUM]):
  - sb_set && sb_addr != 0: sets busy[sb_addr].
  - Popping a FIFO entry to the output clears busy[entry addr].
  - Set and clear of the same address in the same cycle: set wins.
  - Pipeline writes never touch the scoreboard.
  - busy[0] is always 0.
  - busy_1 = busy[rd_addr_1] and busy_2 = busy[rd_addr_2], combinational.
- Starvation:
  - Counter increments when the FIFO is non-empty and the pipeline wins.
  - Counter resets to 0 when a pop occurs or the FIFO is empty; it saturates at STARVE_LIMIT.
  - stall_req is registered; it is 1 when counter >= STARVE_LIMIT.
  - stall_req stays 1 until the next pop, then falls the following cycle.
  - If the pipeline ignores stall_req, the pipeline still wins; no data is lost.

Test Plan:
- Reset, then pipe_we=1, pipe_waddr=5, pipe_wdata=0x1234 for one cycle -> next cycle we=1, waddr=5, wdata=0x1234; the cycle after, we=0.
- sb_set with sb_addr=8, rd_addr_1=8 -> busy_1=1. Then lu handshake (waddr=8, data=0xDEAD) with pipe idle -> we=1, waddr=8 two cycles after the handshake; busy_1 drops the cycle after the pop.
- Hold pipe_we=1 (addr 3) while pushing lu results to addr 9 and addr 10 -> fifo_count=2 and lu_ready=0. After 4 blocked cycles stall_req=1. Drop pipe_we -> addr 9, then addr 10 written in order; stall_req falls after the first pop.
- FIFO full while popping in the same cycle with lu_valid=1 -> lu_ready=0, no push. Next cycle lu_ready=1 and the push succeeds.
- lu_waddr=0 handshake -> fifo_count unchanged, no write. pipe_we with pipe_waddr=0 while FIFO non-empty -> FIFO head is written.
- Assert rst with fifo_count=2 and busy[9]=1 -> next cycle fifo_count=0, busy all 0, we=0, stall_req=0, lu_ready=1 once rst deasserts.
